t05_sram_arbiter: RTL and testbench

Round-robin arbiter that shares the single wishbone_manager CPU-side port among the compression-pipeline requesters: histogram, findLeastValue, hTree, cb_synthesis and translation. It sits between those requesters (or their SRAM-interface request paths) and the wishbone_manager. It serialises one read or write at a time, drives the manager's one-cycle command pulse and tracks BUSY_O to completion. It then returns read data and a one-cycle done strobe to the granted requester.

---
 rtl/t05_arb_pkg.sv | 27 ++
 rtl/t05_rr_picker.sv | 25 ++
 rtl/t05_sram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_t05_sram_arbiter.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t05_arb_pkg.sv
// rtl/t05_arb_pkg.sv - shared state type, requester indices and helpers for the SRAM arbiter
package t05_arb_pkg;

  localparam int ARB_NUM_REQ = 5;

  localparam int ARB_HIST  = 0;
  localparam int ARB_FLV   = 1;
  localparam int ARB_HTREE = 2;
  localparam int ARB_CB    = 3;
  localparam int ARB_TRN   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_START,
    ST_WAIT_END,
    ST_DONE
  } t05_arb_state_t;

  // Index base+off folded back into 0..n-1; off never exceeds n.
  function automatic int rr_wrap(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/t05_rr_picker.sv
// rtl/t05_rr_picker.sv - combinational round-robin picker
// Searches from last+1 with wrap-around and returns a one-hot winner.
module t05_rr_picker import t05_arb_pkg::*; #(
  parameter int NUM_REQ = ARB_NUM_REQ,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] gnt_next,
  output logic               valid
);

  always_comb begin
    gnt_next = '0;
    valid    = 1'b0;
    // Offset NUM_REQ wraps back to last itself, so it ranks behind everyone else.
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!valid && req[rr_wrap(int'(last), i, NUM_REQ)]) begin
        valid = 1'b1;
        gnt_next[rr_wrap(int'(last), i, NUM_REQ)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/t05_sram_arbiter.sv
// rtl/t05_sram_arbiter.sv - round-robin arbiter onto the single wishbone_manager port
// Optional busy watchdog with err abort is compiled in by defining T05_ARB_TIMEOUT_EN.
module t05_sram_arbiter import t05_arb_pkg::*; #(
  parameter int NUM_REQ     = ARB_NUM_REQ,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 hwclk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_we,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  input  logic [NUM_REQ*4-1:0] req_sel,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [31:0]          rdata,
  output logic                 err,
  output logic                 write_i,
  output logic                 read_i,
  output logic [31:0]          addr_i,
  output logic [31:0]          data_i,
  output logic [3:0]           sel_i,
  input  logic                 busy_o,
  input  logic [31:0]          data_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  t05_arb_state_t     state;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   gnt_idx;
  logic               lat_we;
  logic [NUM_REQ-1:0] pick_oh;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_we;
  logic [31:0]        pick_addr;
  logic [31:0]        pick_wdata;
  logic [3:0]         pick_sel;
  logic               tmo_hit;

  t05_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req      (req),
    .last     (last),
    .gnt_next (pick_oh),
    .valid    (pick_valid)
  );

  always_comb begin
    pick_idx   = '0;
    pick_we    = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    pick_sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) begin
        pick_idx   = IDX_W'(i);
        pick_we    = req_we[i];
        pick_addr  = req_addr[i*32 +: 32];
        pick_wdata = req_wdata[i*32 +: 32];
        pick_sel   = req_sel[i*4 +: 4];
      end
    end
  end

`ifdef T05_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             waiting;

  // Counter restarts whenever the wait condition is left, i.e. on every state entry.
  assign waiting = ((state == ST_WAIT_START) && !busy_o) ||
                   ((state == ST_WAIT_END)   &&  busy_o);
  assign tmo_hit = waiting && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (waiting) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      last    <= IDX_W'(NUM_REQ - 1);
      gnt_idx <= '0;
      lat_we  <= 1'b0;
      gnt     <= '0;
      done    <= '0;
      err     <= 1'b0;
      rdata   <= '0;
      write_i <= 1'b0;
      read_i  <= 1'b0;
      addr_i  <= '0;
      data_i  <= '0;
      sel_i   <= '0;
    end else begin
      write_i <= 1'b0;
      read_i  <= 1'b0;
      done    <= '0;
      err     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt     <= pick_oh;
            gnt_idx <= pick_idx;
            lat_we  <= pick_we;
            addr_i  <= pick_addr;
            data_i  <= pick_wdata;
            sel_i   <= pick_sel;
            write_i <= pick_we;
            read_i  <= !pick_we;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT_START;
        end
        ST_WAIT_START: begin
          if (busy_o) begin
            state <= ST_WAIT_END;
          end else if (tmo_hit) begin
            done  <= gnt;
            err   <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_WAIT_END: begin
          if (!busy_o) begin
            if (!lat_we) begin
              rdata <= data_o;
            end
            done  <= gnt;
            state <= ST_DONE;
          end else if (tmo_hit) begin
            done  <= gnt;
            err   <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          last  <= gnt_idx;
          gnt   <= '0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_t05_sram_arbiter.sv
// tb/tb_t05_sram_arbiter.sv - scoreboard bench for the SRAM arbiter with a wishbone_manager model
// Timeout scenario is built only when T05_ARB_TIMEOUT_EN is defined.
module tb_t05_sram_arbiter;
  import t05_arb_pkg::*;

  localparam int N      = ARB_NUM_REQ;
  localparam int TB_TMO = 8;

  logic          hwclk;
  logic          reset;
  logic [N-1:0]  req;
  logic [N-1:0]  req_we;
  logic [N*32-1:0] req_addr;
  logic [N*32-1:0] req_wdata;
  logic [N*4-1:0] req_sel;
  logic [N-1:0]  gnt;
  logic [N-1:0]  done;
  logic [31:0]   rdata;
  logic          err;
  logic          write_i;
  logic          read_i;
  logic [31:0]   addr_i;
  logic [31:0]   data_i;
  logic [3:0]    sel_i;
  logic          busy_o;
  logic [31:0]   data_o;

  typedef struct {
    int          idx;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          mgr_busy_len = 1;
  bit          mgr_stuck = 1'b0;
  logic [31:0] mgr_addr = '0;
  logic [31:0] mgr_wdata = '0;
  logic [3:0]  mgr_sel = '0;
  logic        mgr_we = 1'b0;
  logic [31:0] model_rdata = '0;

  t05_sram_arbiter #(
    .NUM_REQ     (N),
    .TIMEOUT_CYC (TB_TMO)
  ) dut (
    .hwclk     (hwclk),
    .reset     (reset),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_sel   (req_sel),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .write_i   (write_i),
    .read_i    (read_i),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .sel_i     (sel_i),
    .busy_o    (busy_o),
    .data_o    (data_o)
  );

  initial hwclk = 1'b0;
  always #5 hwclk = ~hwclk;

  function automatic logic [31:0] mgr_data(input logic [31:0] a);
    return (a == 32'h0000_0040) ? 32'hDEAD_BEEF : {~a[15:0], a[15:0]};
  endfunction

  // Manager model: busy rises two edges after the command pulse, read data appears as busy falls.
  initial begin
    busy_o = 1'b0;
    data_o = '0;
    forever begin
      @(negedge hwclk);
      if (!reset && (read_i || write_i)) begin
        mgr_addr  = addr_i;
        mgr_wdata = data_i;
        mgr_sel   = sel_i;
        mgr_we    = write_i;
        @(posedge hwclk);
        @(posedge hwclk);
        #1;
        busy_o = 1'b1;
        data_o = 32'h0BAD_0BAD;
        repeat (mgr_busy_len) @(posedge hwclk);
        while (mgr_stuck) @(posedge hwclk);
        #1;
        busy_o = 1'b0;
        data_o = mgr_data(mgr_addr);
      end
    end
  end

  always @(negedge hwclk) begin
    if (!reset) begin
      checks++;
      if ($countones(gnt) > 1 || (write_i && read_i) || ((write_i || read_i) && gnt == '0)) begin
        errors++;
        $display("FAIL invariant t=%0t gnt=%b write_i=%b read_i=%b", $time, gnt, write_i, read_i);
      end
      if (done != '0 || err) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done done=%b err=%b, none expected", done, err);
        end else begin
          mon_e = sb.pop_front();
          if (done !== (5'b1 << mon_e.idx) || err !== mon_e.err || rdata !== mon_e.rdata) begin
            errors++;
            $display("FAIL done_result done=%b err=%b rdata=%h, expected done=%b err=%b rdata=%h",
                     done, err, rdata, 5'b1 << mon_e.idx, mon_e.err, mon_e.rdata);
          end
          checks++;
          if (mgr_addr !== mon_e.addr || mgr_we !== mon_e.we || mgr_sel !== mon_e.sel ||
              (mon_e.we && mgr_wdata !== mon_e.wdata)) begin
            errors++;
            $display("FAIL command got addr=%h we=%b sel=%h wdata=%h, expected addr=%h we=%b sel=%h wdata=%h",
                     mgr_addr, mgr_we, mgr_sel, mgr_wdata, mon_e.addr, mon_e.we, mon_e.sel, mon_e.wdata);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic set_req(input int idx, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] sel);
    req_we[idx]            = we;
    req_addr[idx*32 +: 32] = addr;
    req_wdata[idx*32 +: 32] = wdata;
    req_sel[idx*4 +: 4]    = sel;
  endtask

  task automatic push_exp(input int idx, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] sel, input logic terr);
    exp_t e;
    if (!we && !terr) model_rdata = mgr_data(addr);
    e.idx = idx; e.we = we; e.addr = addr; e.wdata = wdata; e.sel = sel;
    e.rdata = model_rdata; e.err = terr;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int idx, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge hwclk);
      if (done[idx]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_mgr_idle();
    for (int c = 0; c < 100 && busy_o; c++) @(negedge hwclk);
    repeat (2) @(negedge hwclk);
  endtask

  task automatic test_reset();
    checks++;
    if ({gnt, done, err, write_i, read_i} !== '0 || rdata !== '0) begin
      errors++;
      $display("FAIL reset_ctrl gnt=%b done=%b err=%b wr=%b rd=%b rdata=%h, expected all 0",
               gnt, done, err, write_i, read_i, rdata);
    end
    checks++;
    if (addr_i !== '0 || data_i !== '0 || sel_i !== '0) begin
      errors++;
      $display("FAIL reset_bus addr_i=%h data_i=%h sel_i=%h, expected 0", addr_i, data_i, sel_i);
    end
    reset = 1'b0;
    repeat (2) @(negedge hwclk);
    checks++;
    if (gnt !== '0 || read_i !== 1'b0 || write_i !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req gnt=%b rd=%b wr=%b, expected 0", gnt, read_i, write_i);
    end
  endtask

  task automatic test_round_robin();
    int  ndone;
    bit  prev_done;
    mgr_busy_len = 1;
    for (int i = 0; i < N; i++) begin
      set_req(i, logic'(i % 2), 32'h1000 + 32'(i * 16), 32'hA000_0000 | 32'(i), 4'hF ^ 4'(i));
    end
    for (int k = 0; k < 6; k++) begin
      push_exp(k % N, logic'((k % N) % 2), 32'h1000 + 32'((k % N) * 16),
               32'hA000_0000 | 32'(k % N), 4'hF ^ 4'(k % N), 1'b0);
    end
    ndone = 0;
    prev_done = 1'b0;
    req = '1;
    for (int c = 0; c < 300 && ndone < 6; c++) begin
      @(negedge hwclk);
      if (prev_done) begin
        checks++;
        if (gnt !== '0) begin
          errors++;
          $display("FAIL rr_idle_gap gnt=%b, expected 0 in cycle after done", gnt);
        end
      end
      prev_done = (done != '0);
      if (done != '0) begin
        ndone++;
        if (ndone == 5) req[4:1] = '0;
        if (ndone == 6) req = '0;
      end
    end
    checks++;
    if (ndone != 6) begin
      errors++;
      $display("FAIL rr_count got %0d done pulses, expected 6", ndone);
    end
    @(negedge hwclk);
  endtask

  task automatic test_single_read();
    int rd_cnt;
    bit ok;
    logic b1, b2;
    mgr_busy_len = 3;
    set_req(ARB_FLV, 1'b0, 32'h0000_0040, 32'h0, 4'hF);
    push_exp(ARB_FLV, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 1'b0);
    req[ARB_FLV] = 1'b1;
    @(negedge hwclk);
    checks++;
    if (gnt !== 5'b00010 || read_i !== 1'b1 || write_i !== 1'b0) begin
      errors++;
      $display("FAIL flv_grant gnt=%b rd=%b wr=%b, expected 00010 1 0", gnt, read_i, write_i);
    end
    rd_cnt = 1; ok = 1'b0; b1 = 1'b0; b2 = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge hwclk);
      if (done[ARB_FLV]) begin ok = 1'b1; break; end
      rd_cnt += int'(read_i);
      b2 = b1;
      b1 = busy_o;
    end
    checks++;
    if (!ok || rd_cnt != 1 || b1 !== 1'b0 || b2 !== 1'b1) begin
      errors++;
      $display("FAIL flv_timing done_seen=%0d read_cycles=%0d busy_prev=%b busy_prev2=%b, expected 1 1 0 1",
               ok, rd_cnt, b1, b2);
    end
    checks++;
    if (rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL flv_rdata rdata=%h, expected deadbeef", rdata);
    end
    req[ARB_FLV] = 1'b0;
    @(negedge hwclk);
    checks++;
    if (gnt !== '0 || done !== '0) begin
      errors++;
      $display("FAIL flv_release gnt=%b done=%b, expected 0", gnt, done);
    end
  endtask

  task automatic test_addr_latch();
    bit ok;
    mgr_busy_len = 2;
    set_req(ARB_HTREE, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'hF);
    push_exp(ARB_HTREE, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'hF, 1'b0);
    req[ARB_HTREE] = 1'b1;
    @(negedge hwclk);
    checks++;
    if (gnt !== 5'b00100 || write_i !== 1'b1) begin
      errors++;
      $display("FAIL htree_grant gnt=%b wr=%b, expected 00100 1", gnt, write_i);
    end
    set_req(ARB_HTREE, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge hwclk);
      checks++;
      if (addr_i !== 32'h100 || data_i !== 32'h1234_5678 || sel_i !== 4'hF) begin
        errors++;
        $display("FAIL htree_hold addr_i=%h data_i=%h sel_i=%h, expected 100 12345678 f", addr_i, data_i, sel_i);
      end
      if (done[ARB_HTREE]) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL htree_done not seen, expected done[2]");
    end
    req[ARB_HTREE] = 1'b0;
    @(negedge hwclk);
  endtask

  task automatic test_drop_req();
    bit ok;
    mgr_busy_len = 2;
    set_req(ARB_HIST, 1'b0, 32'h0000_0080, 32'h0, 4'h3);
    push_exp(ARB_HIST, 1'b0, 32'h0000_0080, 32'h0, 4'h3, 1'b0);
    req[ARB_HIST] = 1'b1;
    @(negedge hwclk);
    @(negedge hwclk);
    req[ARB_HIST] = 1'b0;
    wait_done(ARB_HIST, 50, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drop_done not seen, expected done[0] after req dropped");
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge hwclk);
      checks++;
      if (gnt !== '0) begin
        errors++;
        $display("FAIL drop_regrant gnt=%b, expected 0", gnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    mgr_busy_len = 2;
    set_req(ARB_CB, 1'b1, 32'h0000_02F0, 32'h0000_0033, 4'h1);
    push_exp(ARB_CB, 1'b1, 32'h0000_02F0, 32'h0000_0033, 4'h1, 1'b0);
    req[ARB_CB] = 1'b1;
    wait_done(ARB_CB, 50, ok);
    req[ARB_CB] = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cb_done not seen, expected done[3]");
    end
    wait_mgr_idle();
    mgr_busy_len = 6;
    set_req(ARB_TRN, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
    push_exp(ARB_TRN, 1'b0, 32'h0000_0300, 32'h0, 4'hF, 1'b0);
    req[ARB_TRN] = 1'b1;
    for (int c = 0; c < 50 && !busy_o; c++) @(negedge hwclk);
    repeat (2) @(negedge hwclk);
    reset = 1'b1;
    #1;
    checks++;
    if ({gnt, done, err, write_i, read_i} !== '0 || rdata !== '0 ||
        addr_i !== '0 || data_i !== '0 || sel_i !== '0) begin
      errors++;
      $display("FAIL mid_reset gnt=%b done=%b err=%b rdata=%h addr_i=%h data_i=%h sel_i=%h, expected all 0",
               gnt, done, err, rdata, addr_i, data_i, sel_i);
    end
    void'(sb.pop_back());
    model_rdata = '0;
    req = '0;
    @(negedge hwclk);
    reset = 1'b0;
    wait_mgr_idle();
    mgr_busy_len = 2;
    set_req(ARB_CB,  1'b0, 32'h0000_0310, 32'h0, 4'hF);
    set_req(ARB_TRN, 1'b0, 32'h0000_0320, 32'h0, 4'hF);
    push_exp(ARB_CB,  1'b0, 32'h0000_0310, 32'h0, 4'hF, 1'b0);
    push_exp(ARB_TRN, 1'b0, 32'h0000_0320, 32'h0, 4'hF, 1'b0);
    req[ARB_TRN:ARB_CB] = 2'b11;
    @(negedge hwclk);
    checks++;
    if (gnt !== 5'b01000) begin
      errors++;
      $display("FAIL post_reset_first gnt=%b, expected 01000", gnt);
    end
    wait_done(ARB_CB, 50, ok);
    req[ARB_CB] = 1'b0;
    wait_done(ARB_TRN, 50, ok);
    req[ARB_TRN] = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL post_reset_second done[4] not seen");
    end
    @(negedge hwclk);
  endtask

`ifdef T05_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int  hi;
    bit  ok;
    mgr_busy_len = 1;
    mgr_stuck = 1'b1;
    set_req(ARB_FLV, 1'b0, 32'h0000_0044, 32'h0, 4'hF);
    push_exp(ARB_FLV, 1'b0, 32'h0000_0044, 32'h0, 4'hF, 1'b1);
    req[ARB_FLV] = 1'b1;
    hi = 0; ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge hwclk);
      if (done[ARB_FLV]) begin ok = 1'b1; break; end
      if (busy_o) hi++;
    end
    // One busy cycle is spent in WAIT_START before the WAIT_END count begins.
    checks++;
    if (!ok || err !== 1'b1 || hi != TB_TMO + 1) begin
      errors++;
      $display("FAIL timeout done_seen=%0d err=%b busy_cycles=%0d, expected 1 1 %0d", ok, err, hi, TB_TMO + 1);
    end
    req[ARB_FLV] = 1'b0;
    mgr_stuck = 1'b0;
    wait_mgr_idle();
  endtask
`endif

  initial begin
    reset = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_sel = '0;
    repeat (3) @(negedge hwclk);
    test_reset();
    test_round_robin();
    test_single_read();
    test_addr_latch();
    test_drop_req();
    test_reset_mid();
`ifdef T05_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (5) @(negedge hwclk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard %0d transactions never completed, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
